frame_writer: RTL and testbench

- Write side of the 400x300, 2-bit-per-channel frame buffer that the VGA pixel output path reads.
- Accepts a raster-ordered pixel stream with a valid/ready handshake and a start-of-frame marker.
- Generates a linear frame-buffer address (index = y*H_PIX + x) and drives a single write port with a one-entry output register that honours memory backpressure.
- Flags frame completion and early start-of-frame errors.

---
 rtl/fb_pkg.sv | 34 +++
 rtl/fb_addr_gen.sv | 81 ++++++++
 rtl/frame_writer.sv | 117 +++++++++++
 tb/tb_frame_writer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// ============================================================================
// Module   : fb_pkg
// Purpose  : Shared frame-buffer geometry, pixel type and write-side state
//            encoding for the VGA frame buffer (writer and reader paths).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package fb_pkg;

  // Frame-buffer geometry: 400x300 source pixels, half the 800 display columns
  localparam int H_PIX    = 400;
  localparam int V_PIX    = 300;
  localparam int FB_DEPTH = H_PIX * V_PIX;
  localparam int ADDR_W   = 17;
  localparam int COLOR_W  = 2;
  localparam int XY_W     = 9;

  // One stored pixel; red occupies the most significant bits
  typedef struct packed {
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
  } rgb_t;

  // Write-side frame state
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } fw_state_e;

endpackage

`default_nettype wire

// File: rtl/fb_addr_gen.sv
// ============================================================================
// Module   : fb_addr_gen
// Purpose  : Raster position counters for the frame writer. Keeps x/y for
//            wrap detection and a linear index that simply increments.
//            'step' advances from the current position, 'restart' treats the
//            current pixel as (0,0) and advances from there.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fb_addr_gen #(
  parameter int H_PIX  = fb_pkg::H_PIX,
  parameter int V_PIX  = fb_pkg::V_PIX,
  parameter int ADDR_W = fb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic              restart,
  output logic [ADDR_W-1:0] index,
  output logic              is_last
);

  localparam int XY_W = fb_pkg::XY_W;
  localparam logic [XY_W-1:0] X_LAST = XY_W'(H_PIX - 1);
  localparam logic [XY_W-1:0] Y_LAST = XY_W'(V_PIX - 1);
  localparam logic ONE_PIXEL = (H_PIX * V_PIX == 1);

  logic [XY_W-1:0]   x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  // Position the pixel being written occupies (restart means pixel (0,0))
  logic [XY_W-1:0]   base_x, base_y;
  logic [ADDR_W-1:0] base_idx;
  logic              base_last;

  assign is_last = (x_q == X_LAST) && (y_q == Y_LAST);
  assign index   = idx_q;

  // Next position: advance one pixel from the base, wrapping row and frame
  always_comb begin
    base_x    = restart ? '0 : x_q;
    base_y    = restart ? '0 : y_q;
    base_idx  = restart ? '0 : idx_q;
    base_last = restart ? ONE_PIXEL : is_last;
    x_d       = x_q;
    y_d       = y_q;
    idx_d     = idx_q;
    if (step || restart) begin
      if (base_last) begin
        x_d   = '0;
        y_d   = '0;
        idx_d = '0;
      end else if (base_x == X_LAST) begin
        x_d   = '0;
        y_d   = base_y + XY_W'(1);
        idx_d = base_idx + ADDR_W'(1);
      end else begin
        x_d   = base_x + XY_W'(1);
        y_d   = base_y;
        idx_d = base_idx + ADDR_W'(1);
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q   <= '0;
      y_q   <= '0;
      idx_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      idx_q <= idx_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/frame_writer.sv
// ============================================================================
// Module   : frame_writer
// Purpose  : Write side of the VGA frame buffer. Takes a raster pixel stream
//            with start-of-frame, produces linear addresses and drives one
//            write port through a single output register with backpressure.
//            Flags frame completion and early start-of-frame.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module frame_writer #(
  parameter int H_PIX  = fb_pkg::H_PIX,
  parameter int V_PIX  = fb_pkg::V_PIX,
  parameter int ADDR_W = fb_pkg::ADDR_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_sof,
  input  logic [fb_pkg::COLOR_W-1:0]   in_red,
  input  logic [fb_pkg::COLOR_W-1:0]   in_green,
  input  logic [fb_pkg::COLOR_W-1:0]   in_blue,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [3*fb_pkg::COLOR_W-1:0] mem_rgb,
  input  logic                         mem_ready,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         sof_err
);

  localparam logic ONE_PIXEL = (H_PIX * V_PIX == 1);

  fb_pkg::fw_state_e state_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  fb_pkg::rgb_t      rgb_q;
  logic              last_q;   // pending write is the final pixel of a frame
  logic              done_q;
  logic              err_q;

  logic              in_acc, mem_acc;
  logic              gen_step, gen_restart;
  logic [ADDR_W-1:0] gen_index;
  logic              gen_is_last;
  fb_pkg::rgb_t      in_pix;

  // The output register frees up when empty or draining this cycle
  assign in_ready    = !reset && (!we_q || mem_ready);
  assign in_acc      = in_valid && in_ready;
  assign mem_acc     = we_q && mem_ready;
  assign gen_restart = in_acc && in_sof;
  assign gen_step    = in_acc && !in_sof && (state_q == fb_pkg::WRITE);
  assign in_pix      = '{red: in_red, green: in_green, blue: in_blue};

  fb_addr_gen #(
    .H_PIX  (H_PIX),
    .V_PIX  (V_PIX),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .step    (gen_step),
    .restart (gen_restart),
    .index   (gen_index),
    .is_last (gen_is_last)
  );

  // Frame FSM, pending write register and status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= fb_pkg::IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      rgb_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= mem_acc && last_q;
      err_q  <= 1'b0;
      if (mem_acc) begin
        we_q <= 1'b0;
      end
      if (in_acc) begin
        if (in_sof) begin
          // A new frame always starts at address 0, even mid-frame
          we_q    <= 1'b1;
          addr_q  <= '0;
          rgb_q   <= in_pix;
          last_q  <= ONE_PIXEL;
          err_q   <= (state_q == fb_pkg::WRITE);
          state_q <= ONE_PIXEL ? fb_pkg::IDLE : fb_pkg::WRITE;
        end else if (state_q == fb_pkg::WRITE) begin
          we_q   <= 1'b1;
          addr_q <= gen_index;
          rgb_q  <= in_pix;
          last_q <= gen_is_last;
          if (gen_is_last) begin
            state_q <= fb_pkg::IDLE;
          end
        end
      end
    end
  end

  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_rgb    = rgb_q;
  assign frame_done = done_q;
  assign sof_err    = err_q;
  assign busy       = (state_q == fb_pkg::WRITE) || we_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_writer.sv
// ============================================================================
// Module   : tb_frame_writer
// Purpose  : Self-checking bench for frame_writer. A reduced-height frame
//            keeps full frames short while the row width stays at 400.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_frame_writer;

  localparam int TB_H = 400;
  localparam int TB_V = 8;
  localparam int TB_D = TB_H * TB_V;
  localparam int CW   = fb_pkg::COLOR_W;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid, in_ready, in_sof;
  logic [CW-1:0]   in_red, in_green, in_blue;
  logic            mem_we, mem_ready;
  logic [16:0]     mem_addr;
  logic [3*CW-1:0] mem_rgb;
  logic            busy, frame_done, sof_err;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: transaction-level view of the pending write and frame
  bit              m_we, m_last, m_done, m_err, inframe, mon_on;
  int              m_addr, pos, done_seen, base_done;
  logic [3*CW-1:0] m_rgb;

  always #5 clk = ~clk;

  frame_writer #(.H_PIX(TB_H), .V_PIX(TB_V), .ADDR_W(17)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sof     (in_sof),
    .in_red     (in_red),
    .in_green   (in_green),
    .in_blue    (in_blue),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_rgb    (mem_rgb),
    .mem_ready  (mem_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .sof_err    (sof_err)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply(bit v, bit s, bit mr);
    in_valid  = v;
    in_sof    = s;
    in_red    = CW'($urandom);
    in_green  = CW'($urandom);
    in_blue   = CW'($urandom);
    mem_ready = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit coin();
    return $urandom_range(0, 3) != 0;
  endfunction

  // Compare against the model mid-cycle, then predict the next edge
  always @(negedge clk) begin
    bit exp_ready, acc, macc;
    if (mon_on) begin
      check("mem_we", mem_we, m_we);
      if (m_we) begin
        check("mem_addr", mem_addr, m_addr);
        check("mem_rgb", mem_rgb, m_rgb);
      end
      check("frame_done", frame_done, m_done);
      check("sof_err", sof_err, m_err);
      check("busy", busy, inframe || m_we);
      exp_ready = !reset && (!m_we || mem_ready);
      check("in_ready", in_ready, exp_ready);
      if (frame_done === 1'b1) done_seen++;
      if (reset) begin
        m_we = 0; m_last = 0; m_done = 0; m_err = 0; inframe = 0;
        m_addr = 0; pos = 0; m_rgb = '0;
      end else begin
        acc    = in_valid && exp_ready;
        macc   = m_we && mem_ready;
        m_done = macc && m_last;
        m_err  = 0;
        if (macc) m_we = 0;
        if (acc && in_sof) begin
          m_err   = inframe;
          m_addr  = 0;
          m_last  = 0;
          pos     = 1;
          inframe = 1;
          m_we    = 1;
          m_rgb   = {in_red, in_green, in_blue};
        end else if (acc && inframe) begin
          m_addr  = pos;
          m_last  = (pos == TB_D - 1);
          pos     = m_last ? 0 : pos + 1;
          inframe = !m_last;
          m_we    = 1;
          m_rgb   = {in_red, in_green, in_blue};
        end
      end
    end
  end

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    apply(0, 0, 1);
    @(posedge clk);
    #1;
    mon_on = 1;
    tick();
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    reset = 1'b0;

    // Pixels before any start-of-frame are dropped
    repeat (5) begin
      apply(1, 0, 1);
      tick();
      check("idle_no_we", mem_we, 0);
    end
    apply(1, 1, 1);
    in_red = 2'd3; in_green = 2'd0; in_blue = 2'd1;
    tick();
    check("sof_we", mem_we, 1);
    check("sof_addr", mem_addr, 0);
    check("sof_rgb", mem_rgb, 6'b110001);

    // Full-rate stream up to the end of row 0, then memory stall
    while (!(m_we && m_addr == TB_H - 1)) begin
      apply(1, 0, 1);
      tick();
    end
    repeat (3) begin
      apply(1, 0, 0);
      #1;
      check("stall_ready", in_ready, 0);
      tick();
      check("stall_addr", mem_addr, TB_H - 1);
    end
    apply(1, 0, 1);
    tick();
    check("wrap_addr", mem_addr, 1 * TB_H + 0);

    // Rest of frame at full rate
    while (inframe) begin
      apply(1, 0, 1);
      tick();
    end
    apply(0, 0, 1);
    tick();
    tick();
    check("f1_done_cnt", done_seen, 1);
    check("f1_busy", busy, 0);

    // Random traffic with an early start-of-frame at pixel 1000
    apply(1, 1, 1);
    tick();
    base_done = done_seen;
    do begin
      apply(coin(), inframe && pos == 1000, coin());
      tick();
    end while (!m_err);
    check("esof_err", sof_err, 1);
    check("esof_addr", mem_addr, 0);
    apply(1, 0, 1);
    tick();
    check("esof_pulse", sof_err, 0);
    check("esof_next", mem_addr, 1);
    while (!(m_we && m_last)) begin
      apply(coin(), 0, coin());
      tick();
    end
    check("esof_no_done", done_seen, base_done);

    // Last write drains while a new frame starts
    apply(1, 1, 1);
    tick();
    check("sim_done", frame_done, 1);
    check("sim_addr", mem_addr, 0);
    check("sim_err", sof_err, 0);

    // Reset with a stalled write pending
    while (!(m_we && m_addr == 2000)) begin
      apply(coin(), 0, 1);
      tick();
    end
    apply(0, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_we", mem_we, 0);
    check("rst2_busy", busy, 0);
    repeat (10) begin
      apply(1, 0, 1);
      tick();
    end
    check("post_rst_we", mem_we, 0);

    // Start-of-frame landing exactly on the last index
    apply(1, 1, 1);
    tick();
    base_done = done_seen;
    while (pos != TB_D - 1) begin
      apply(1, 0, coin());
      tick();
    end
    apply(1, 1, 1);
    tick();
    check("lsof_err", sof_err, 1);
    check("lsof_addr", mem_addr, 0);
    apply(0, 0, 1);
    repeat (4) tick();
    check("lsof_no_done", done_seen, base_done);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
